// File: rtl/blink_pkg.sv
// Shared types and helpers for the status-LED blink arbiter.
//   blink_state_t : FSM state encoding (IDLE, ON, OFF)
//   div_f         : clock-to-tick divide ratio
//   prio_enc_f    : lowest-set-bit priority encoder (one-hot plus index)
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } blink_state_t;

    // Widest requester vector the priority encoder handles.
    localparam int MAX_REQ = 32;
    localparam int IDX_W   = 5;

    typedef struct packed {
        logic [MAX_REQ-1:0] onehot;
        logic [IDX_W-1:0]   idx;
    } prio_t;

    function automatic int div_f(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Scans from the top down so the lowest set index is the last write.
    function automatic prio_t prio_enc_f(input logic [MAX_REQ-1:0] req);
        prio_t r;
        r.onehot = '0;
        r.idx    = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                r.onehot    = '0;
                r.onehot[k] = 1'b1;
                r.idx       = IDX_W'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk_25m_i down to a one-cycle tick every DIV cycles.
//   clk_25m_i : clock
//   rst_n_i   : synchronous active-low reset
//   clr_i     : synchronous clear, wins over counting
//   tick_o    : high during the last cycle of each DIV-cycle window
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk_25m_i,
    input  logic rst_n_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_25m_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/led_blink_arbiter.sv
// Shares one status LED between N_REQ requesters. A fixed-priority pick
// (index 0 highest) chooses the owner, which then gets a full ON and OFF
// phase of its own half-period before anyone else is considered.
//   clk_25m_i     : clock
//   rst_n_i       : synchronous active-low reset
//   req_i         : level request per requester
//   half_period_i : packed half-periods in ticks, field k at [k*PERIOD_W +: PERIOD_W]
//   grant_o       : one-hot LED owner, zero when idle
//   busy_o        : high while a blink period is in progress
//   led_o         : LED drive, active high
//
// state | meaning
// IDLE  | no owner, LED dark, waiting for any request
// ON    | owner's lit half-period is running
// OFF   | owner's dark half-period; re-arbitrates when it expires
module led_blink_arbiter
    import blink_pkg::*;
#(
    parameter int CLK_HZ   = 25000000,
    parameter int TICK_HZ  = 1000,
    parameter int N_REQ    = 4,
    parameter int PERIOD_W = 16
) (
    input  logic                      clk_25m_i,
    input  logic                      rst_n_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*PERIOD_W-1:0] half_period_i,
    output logic [N_REQ-1:0]          grant_o,
    output logic                      busy_o,
    output logic                      led_o
);

    localparam int DIV = div_f(CLK_HZ, TICK_HZ);

    if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
        $error("led_blink_arbiter: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
    if (N_REQ < 1 || N_REQ > MAX_REQ) begin : g_bad_nreq
        $error("led_blink_arbiter: N_REQ out of range");
    end

    blink_state_t        state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic                led_q, led_d;
    logic                busy_q;
    logic [PERIOD_W-1:0] hp_q, hp_d;
    logic [PERIOD_W-1:0] tcnt_q, tcnt_d;
    logic                clr;
    logic                tick;
    logic                phase_end;

    prio_t               pe;
    logic                any_req;
    logic [PERIOD_W-1:0] hp_raw;
    logic [PERIOD_W-1:0] hp_sel;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk_25m_i (clk_25m_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (clr),
        .tick_o    (tick)
    );

    assign pe      = prio_enc_f(MAX_REQ'(req_i));
    assign any_req = |pe.onehot;

    // A zero half-period would never expire against the tick counter,
    // so it is promoted to one tick.
    always_comb begin
        hp_raw = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pe.idx == IDX_W'(k)) begin
                hp_raw = half_period_i[k*PERIOD_W +: PERIOD_W];
            end
        end
        hp_sel = (hp_raw == '0) ? PERIOD_W'(1) : hp_raw;
    end

    // hp_q is at least 1 in ON/OFF, so hp_q-1 never underflows there.
    assign phase_end = tick && (tcnt_q == hp_q - PERIOD_W'(1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        led_d   = led_q;
        hp_d    = hp_q;
        tcnt_d  = tcnt_q;
        clr     = 1'b0;

        case (state_q)
            IDLE: begin
                led_d = 1'b0;
                if (any_req) begin
                    state_d = ON;
                    grant_d = pe.onehot[N_REQ-1:0];
                    hp_d    = hp_sel;
                    led_d   = 1'b1;
                    tcnt_d  = '0;
                    clr     = 1'b1;
                end
            end
            ON: begin
                if (phase_end) begin
                    state_d = OFF;
                    led_d   = 1'b0;
                    tcnt_d  = '0;
                end else if (tick) begin
                    tcnt_d = tcnt_q + PERIOD_W'(1);
                end
            end
            OFF: begin
                if (phase_end) begin
                    tcnt_d = '0;
                    if (any_req) begin
                        state_d = ON;
                        grant_d = pe.onehot[N_REQ-1:0];
                        hp_d    = hp_sel;
                        led_d   = 1'b1;
                        clr     = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        led_d   = 1'b0;
                    end
                end else if (tick) begin
                    tcnt_d = tcnt_q + PERIOD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                led_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_25m_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            hp_q    <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            led_q   <= led_d;
            busy_q  <= (state_d != IDLE);
            hp_q    <= hp_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = busy_q;
    assign led_o   = led_q;

endmodule

// File: tb/tb_led_blink_arbiter.sv
module tb_led_blink_arbiter;

    localparam int CLK_HZ   = 100;
    localparam int TICK_HZ  = 10;
    localparam int DIV      = CLK_HZ / TICK_HZ;
    localparam int N_REQ    = 4;
    localparam int PERIOD_W = 8;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*PERIOD_W-1:0] hp_in;
    logic [N_REQ-1:0]          grant_o;
    logic                      busy_o;
    logic                      led_o;

    led_blink_arbiter #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .N_REQ    (N_REQ),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .clk_25m_i     (clk),
        .rst_n_i       (rst_n),
        .req_i         (req),
        .half_period_i (hp_in),
        .grant_o       (grant_o),
        .busy_o        (busy_o),
        .led_o         (led_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        logic [N_REQ-1:0] g;
        logic             led;
        logic             busy;
    } ev_t;

    ev_t q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    // Reference model: tracks owner, phase and the absolute cycle at which
    // the current phase expires; pushes every change of the outputs.
    int               m_phase = 0;   // 0 idle, 1 lit, 2 dark
    int               m_owner = -1;
    int               m_hp    = 0;
    int               m_end   = 0;
    logic [N_REQ-1:0] m_g_prev = '0;
    logic             m_l_prev = 1'b0;
    logic             m_b_prev = 1'b0;

    task automatic model_pick(input int n);
        int f;
        m_owner = -1;
        for (int k = N_REQ - 1; k >= 0; k--) if (req[k]) m_owner = k;
        if (m_owner < 0) begin
            m_phase = 0;
        end else begin
            f       = int'(hp_in[m_owner*PERIOD_W +: PERIOD_W]);
            m_hp    = (f == 0) ? 1 : f;
            m_phase = 1;
            m_end   = n + m_hp * DIV;
        end
    endtask

    initial begin
        logic [N_REQ-1:0] g;
        ev_t              e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                m_phase = 0;
                m_owner = -1;
            end else if (m_phase == 0) begin
                if (req != '0) model_pick(cyc);
            end else if (m_phase == 1) begin
                if (cyc == m_end) begin
                    m_phase = 2;
                    m_end   = cyc + m_hp * DIV;
                end
            end else begin
                if (cyc == m_end) model_pick(cyc);
            end
            g = (m_owner < 0) ? '0 : N_REQ'(1 << m_owner);
            if (g != m_g_prev || (m_phase == 1) != m_l_prev || (m_phase != 0) != m_b_prev) begin
                e.cyc  = cyc;
                e.g    = g;
                e.led  = (m_phase == 1);
                e.busy = (m_phase != 0);
                q.push_back(e);
                m_g_prev = e.g;
                m_l_prev = e.led;
                m_b_prev = e.busy;
            end
        end
    end

    // Monitor: every change on the DUT outputs consumes one expected event.
    initial begin
        logic [N_REQ-1:0] p_g = '0;
        logic             p_l = 1'b0;
        logic             p_b = 1'b0;
        ev_t              e;
        forever begin
            @(posedge clk);
            #2;
            if (grant_o != p_g || led_o != p_l || busy_o != p_b) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL event: cycle %0d grant=%b led=%b busy=%b, required no change",
                             cyc, grant_o, led_o, busy_o);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.g != grant_o || e.led != led_o || e.busy != busy_o) begin
                        n_bad++;
                        $display("FAIL event: cycle %0d grant=%b led=%b busy=%b, required cycle %0d grant=%b led=%b busy=%b",
                                 cyc, grant_o, led_o, busy_o, e.cyc, e.g, e.led, e.busy);
                    end
                end
                p_g = grant_o;
                p_l = led_o;
                p_b = busy_o;
            end
        end
    end

    task automatic chk(input string name, input logic [N_REQ-1:0] g, input logic l, input logic b);
        n_cmp++;
        if (grant_o != g || led_o != l || busy_o != b) begin
            n_bad++;
            $display("FAIL %s: grant=%b led=%b busy=%b, required grant=%b led=%b busy=%b",
                     name, grant_o, led_o, busy_o, g, l, b);
        end
    endtask

    function automatic logic [N_REQ*PERIOD_W-1:0] pack(input int f0, input int f1, input int f2, input int f3);
        return {PERIOD_W'(f3), PERIOD_W'(f2), PERIOD_W'(f1), PERIOD_W'(f0)};
    endfunction

    task automatic run(input logic [N_REQ-1:0] r, input logic [N_REQ*PERIOD_W-1:0] h, input int cycles);
        @(negedge clk);
        req   = r;
        hp_in = h;
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_abort", '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        hp_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // steady blink of requester 1 at 3 ticks
        @(negedge clk);
        req   = 4'b0010;
        hp_in = pack(0, 3, 0, 0);
        @(posedge clk);
        #1;
        chk("first_grant", 4'b0010, 1'b1, 1'b1);
        run(4'b0010, pack(0, 3, 0, 0), 130);
        run(4'b0000, pack(0, 3, 0, 0), 70);
        chk("idle_after_drop", '0, 1'b0, 1'b0);

        // two requesters, winner drops during its OFF phase
        run(4'b1010, pack(0, 2, 0, 5), 25);
        run(4'b1000, pack(0, 2, 0, 5), 100);
        run(4'b0000, pack(0, 2, 0, 5), 110);

        // higher priority arrives mid-period and must wait
        run(4'b1000, pack(1, 0, 0, 4), 5);
        run(4'b1001, pack(1, 0, 0, 4), 120);
        run(4'b0000, pack(1, 0, 0, 4), 90);

        // owner drops request at cycle 5, period still completes
        run(4'b0100, pack(0, 0, 2, 0), 5);
        run(4'b0000, pack(0, 0, 2, 0), 60);
        chk("idle_after_release", '0, 1'b0, 1'b0);

        // zero half-period acts as 1; mid-period change waits for re-arbitration
        run(4'b0001, pack(0, 0, 0, 0), 15);
        run(4'b0001, pack(7, 0, 0, 0), 40);
        run(4'b0000, pack(7, 0, 0, 0), 160);

        // reset mid-ON, then a full-length re-grant
        run(4'b0001, pack(2, 0, 0, 0), 15);
        rst_pulse();
        @(posedge clk);
        #1;
        chk("regrant_after_reset", 4'b0001, 1'b1, 1'b1);
        run(4'b0001, pack(2, 0, 0, 0), 40);
        run(4'b0000, pack(2, 0, 0, 0), 60);

        // randomized traffic
        for (int i = 0; i < 250; i++) begin
            logic [N_REQ-1:0] r;
            r = ($urandom_range(0, 3) == 0) ? '0 : N_REQ'($urandom_range(0, 15));
            if ($urandom_range(0, 24) == 0) rst_pulse();
            run(r, pack($urandom_range(0, 4), $urandom_range(0, 4),
                        $urandom_range(0, 4), $urandom_range(0, 4)),
                $urandom_range(1, 40));
        end

        run(4'b0000, '0, 200);
        chk("final_idle", '0, 1'b0, 1'b0);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: %0d left, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_blink_arbiter.md
Name: led_blink_arbiter

Overview:
Shares the board's single status LED between N_REQ requesters. Each requester has its own blink rate. A fixed-priority arbiter picks one requester, and a timed ON/OFF state machine blinks the LED at that requester's half-period. The block sits beside the PLLs in the top level, in the 25 MHz input clock domain, and replaces free-running per-clock blink counters.

Parameters:
CLK_HZ, 25000000, input clock frequency in Hz
TICK_HZ, 1000, phase-timer tick rate; DIV = CLK_HZ/TICK_HZ; elaboration error if DIV < 2 or CLK_HZ % TICK_HZ != 0
N_REQ, 4, number of requesters; index 0 has the highest priority
PERIOD_W, 16, width of each half-period field, in ticks

Ports:
clk_25m_i  in  1  sole clock; all logic on its rising edge
rst_n_i  in  1  synchronous, active-low reset
req_i  in  N_REQ  level request per requester
half_period_i  in  N_REQ*PERIOD_W  packed half-periods in ticks; field k is bits [k*PERIOD_W +: PERIOD_W]
grant_o  out  N_REQ  one-hot owner of the LED; all zeros when idle
busy_o  out  1  high whenever state != IDLE
led_o  out  1  LED drive, active high

Behaviour:
- Clocking and reset: one clock, clk_25m_i. Reset is synchronous and active-low on rst_n_i.
- While rst_n_i=0, on every edge: state=IDLE, grant_o=0, busy_o=0, led_o=0, prescaler=0, tick counter=0, latched half-period=0.
- Reset mid-blink aborts immediately. On the next edge the LED is off and nothing is granted.
- All outputs are registered.
- FSM states: IDLE, ON, OFF.
- Prescaler: counts 0..DIV-1 and pulses tick when it reaches DIV-1. It is cleared when entering ON from IDLE or OFF, so phases are cycle-exact.
- IDLE: led_o=0.
  - If req_i != 0, at the next edge: grant_o = lowest set index, hp = that requester's half-period latched (0 treated as 1), state=ON, led_o=1.
  - Latency: req sampled at edge n gives led_o=1 and grant_o valid after edge n.
- ON:
  - Ticks are counted. When the count reaches hp: state=OFF, led_o=0, count cleared.
  - ON lasts exactly hp*DIV cycles.
- OFF:
  - Ticks are counted. When the count reaches hp, re-arbitration happens on that same edge.
  - If req_i != 0: grant the lowest set index, latch the new hp, go to ON with led_o=1. The winner may be the same requester.
  - Else: go to IDLE and set grant_o=0.
  - OFF lasts exactly hp*DIV cycles.
- Non-preemption: grant changes only at the end of an OFF phase.
  - A higher-priority request arriving mid-period waits for the current period to complete.
  - If the granted requester drops req mid-period, the current ON/OFF period still completes.
- Stable rate: half_period_i changes after grant are ignored until the next arbitration.
- Simultaneous requests: the lowest index wins. There is no fairness or round-robin, and starvation of low-priority requesters is accepted by design.
- Width rules:
  - The tick counter is PERIOD_W bits and compared against hp. It cannot wrap, because it is cleared at hp.
  - The prescaler is $clog2(DIV) bits.
- busy_o = (state != IDLE). grant_o is one-hot or zero in every cycle.

Decomposition:
- Package blink_pkg holds:
  - the state enum (IDLE, ON, OFF)
  - a function div_f(CLK_HZ, TICK_HZ)
  - a lowest-set-bit priority-encode function returning a one-hot vector and an index
- One sub-module, tick_prescaler:
  - ports: clk_25m_i, rst_n_i, clr_i, tick_o
  - parameter DIV
  - synchronous clear takes priority over counting.

Test Plan (CLK_HZ=100, TICK_HZ=10, so DIV=10; N_REQ=4, PERIOD_W=8):
1. Reset, then req_i=4'b0010 with field1=3 held -> one edge later grant_o=0010, led_o=1. led_o stays high 30 cycles, low 30 cycles, repeating. busy_o=1 throughout.
2. req_i=4'b1010 from IDLE with field1=2 and field3=5 -> grant_o=0010, ON 20 cycles, OFF 20 cycles. Drop req1 during OFF -> after OFF ends, grant_o=1000, ON 50 cycles.
3. Granted req3 (hp=4); assert req0 (hp=1) 5 cycles into ON -> no change until OFF ends at cycle 80 from grant. Then grant_o=0001, ON 10 cycles.
4. Granted req2 (hp=2); deassert all req at cycle 5 -> ON still 20 cycles, OFF 20 cycles. Then grant_o=0, busy_o=0, led_o=0.
5. field0=0 with req0 -> treated as hp=1: 10 cycles on, 10 cycles off. Changing field0 to 7 mid-period does not alter timing until re-arbitration.
6. Assert rst_n_i=0 for one cycle 15 cycles into ON -> next edge: led_o=0, grant_o=0, busy_o=0. After release with req held, re-grant follows one edge later and gives a full-length ON phase.
